hazard_scoreboard_ctrlr: RTL and testbench
==========================================

// Module: hazard_scoreboard_ctrlr
// PURPOSE
//  Parametrised hazard/forwarding controller for the D->E->M->W pipeline, with a multi-cycle MUL/DIV unit.
//  - Tracks in-flight destinations of the E, M and W stages in its own registered shadow pipeline.
//  - Decides the decode-stage stall and the per-operand bypass selects.
//  - Holds a busy countdown for the MUL/DIV unit and a saturating stall-cycle counter.
// PARAMETERS
//  ADDR_W       5   register address width
//  MULDIV_LAT   4   MUL/DIV cycles from issue to regfile write (>=2)
//  CNT_W        16  stall counter width
//  ZERO_REG     1   1: register 0 is hardwired; it never causes a hazard or a bypass
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high reset
//  i_issue_valid in   1       decode holds a valid instruction
//  i_rs_addr     in   ADDR_W  source A address
//  i_rs_used     in   1       source A is read
//  i_rt_addr     in   ADDR_W  source B address
//  i_rt_used     in   1       source B is read
//  i_dst_addr    in   ADDR_W  destination address
//  i_dst_wr      in   1       instruction writes i_dst_addr
//  i_dst_class   in   2       0=ALU 1=LOAD 2=MULDIV 3=treated as ALU
//  i_flush       in   1       kill decode instr and E-stage entry (branch redirect)
//  i_cnt_clear   in   1       synchronous clear of o_stall_count
//  o_stall       out  1       hold decode/fetch, inject bubble into E
//  o_rs_fwd_sel  out  2       0=regfile 1=EX result 2=MEM result 3=WB result
//  o_rt_fwd_sel  out  2       same encoding for source B
//  o_muldiv_busy out  1       MUL/DIV countdown nonzero
//  o_stall_count out  CNT_W   saturating count of stalled issue cycles
// BEHAVIOUR
//  Reset state: E/M/W entries invalid; countdown 0; muldiv dst 0; o_stall_count 0.
//  While reset is asserted, o_stall=0 and both fwd_sel=0.
//  Shadow pipe: each stage entry holds {valid, addr, class}; it advances E->M->W every cycle (no back-pressure).
//  E capture: E <= decode entry when issue_valid & ~stall & ~flush & dst_wr & class!=MULDIV; otherwise E invalid.
//  A source "matches" a stage when: used, stage valid, addr equal, and not (ZERO_REG & addr==0).
//  Stall sources (combinational, evaluated only when i_issue_valid):
//   - Load-use: any source matches E with class LOAD.
//   - MULDIV RAW: any source equals the muldiv dst while countdown!=0.
//   - MULDIV WAW: dst_wr & dst==muldiv dst while countdown!=0.
//   - Structural: class MULDIV while countdown>1.
//   - i_flush forces o_stall=0.
//  Bypass select per source, youngest first:
//   - E match with class ALU -> 1; M match -> 2; W match -> 3; else 0.
//   - A LOAD in E never yields select 1 (that case is a stall).
//  MULDIV:
//   - Accepted issue loads countdown=MULDIV_LAT and latches dst; countdown decrements to 0.
//   - The unit writes the regfile on the 1->0 transition over its own port; consumers then read the regfile (sel 0).
//   - MULDIV with dst_wr=0 still occupies the unit.
//   - MULDIV accepted on the same cycle countdown==1: reload wins.
//  Flush:
//   - Invalidates the decode capture and the E entry next cycle; M and W entries are untouched.
//   - The MUL/DIV countdown is never cancelled.
//  Stall counter:
//   - +1 per cycle with i_issue_valid & o_stall, saturating at all-ones.
//   - i_cnt_clear takes priority over increment.
//  Outputs o_stall and fwd_sel are combinational (same-cycle); all state changes on clock.
//  Async reset mid-operation drops all in-flight entries and the countdown immediately.
// TESTING
//  T1: ALU r3 issued, then ADD rs=r3 next cycle -> no stall; rs_fwd_sel=1; next cycle a user of r3 sees sel=2, then sel=3.
//  T2: LW r5, then ADD rt=r5 -> o_stall=1 for 1 cycle, stall_count=1; then rt_fwd_sel=2.
//  T3: MUL r7 (LAT=4), then ADD rs=r7 -> stall 4 cycles; o_muldiv_busy high 4 cycles; ADD then issues with sel=0.
//  T4: ALU r0, then user of r0 with ZERO_REG=1 -> sel=0, no stall. Same with ZERO_REG=0 -> sel=1.
//  T5: LW r9 in E with i_flush=1 and a user of r9 in D -> o_stall=0; the next cycle's E entry is invalid.
//  T6: Stall held 2^CNT_W+3 cycles -> count saturates at all-ones. Assert reset mid-MUL -> busy=0, count=0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_ctrlr.sv
// hazard_scoreboard_ctrlr
//  Hazard/forwarding controller for a D->E->M->W pipeline with a multi-cycle
//  MUL/DIV unit. Keeps a registered shadow of the E/M/W destinations, decides
//  the decode stall and per-operand bypass selects, tracks MUL/DIV occupancy
//  and counts stalled issue cycles (saturating).
// Ports
//  clock, reset                 rising-edge clock, async active-high reset
//  i_issue_valid                decode holds a valid instruction
//  i_rs_addr/i_rs_used          source A address / read enable
//  i_rt_addr/i_rt_used          source B address / read enable
//  i_dst_addr/i_dst_wr          destination address / write enable
//  i_dst_class                  0=ALU 1=LOAD 2=MULDIV 3=ALU
//  i_flush                      kill decode instruction and E entry
//  i_cnt_clear                  synchronous clear of o_stall_count
//  o_stall                      hold decode/fetch, bubble into E (comb)
//  o_rs_fwd_sel/o_rt_fwd_sel    0=regfile 1=EX 2=MEM 3=WB (comb)
//  o_muldiv_busy                MUL/DIV countdown nonzero
//  o_stall_count                saturating stalled-issue-cycle count
module hazard_scoreboard_ctrlr #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic              i_rs_used,
    input  logic [ADDR_W-1:0] i_rt_addr,
    input  logic              i_rt_used,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic              i_dst_wr,
    input  logic [1:0]        i_dst_class,
    input  logic              i_flush,
    input  logic              i_cnt_clear,
    output logic              o_stall,
    output logic [1:0]        o_rs_fwd_sel,
    output logic [1:0]        o_rt_fwd_sel,
    output logic              o_muldiv_busy,
    output logic [CNT_W-1:0]  o_stall_count
);

    localparam int unsigned CD_W = $clog2(MULDIV_LAT + 1);
    localparam logic [1:0] CLS_LOAD   = 2'd1;
    localparam logic [1:0] CLS_MULDIV = 2'd2;

    // Shadow pipeline entries
    logic              e_valid, m_valid, w_valid;
    logic [ADDR_W-1:0] e_addr, m_addr, w_addr;
    logic [1:0]        e_class, m_class, w_class;

    // MUL/DIV occupancy
    logic [CD_W-1:0]   md_cnt;
    logic [ADDR_W-1:0] md_dst;
    logic              md_wr;

    logic [CNT_W-1:0]  stall_cnt;

    logic rs_ok, rt_ok;
    logic rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
    logic md_busy_c, stall_c, accept_c, is_md_c;

    // A source participates only if read and not the hardwired zero register
    assign rs_ok = i_rs_used && !((ZERO_REG != 0) && (i_rs_addr == '0));
    assign rt_ok = i_rt_used && !((ZERO_REG != 0) && (i_rt_addr == '0));

    assign rs_e = rs_ok && e_valid && (e_addr == i_rs_addr);
    assign rs_m = rs_ok && m_valid && (m_addr == i_rs_addr);
    assign rs_w = rs_ok && w_valid && (w_addr == i_rs_addr);
    assign rt_e = rt_ok && e_valid && (e_addr == i_rt_addr);
    assign rt_m = rt_ok && m_valid && (m_addr == i_rt_addr);
    assign rt_w = rt_ok && w_valid && (w_addr == i_rt_addr);

    assign md_busy_c = (md_cnt != '0);
    assign is_md_c   = (i_dst_class == CLS_MULDIV);

    // Stall decision; flush and reset force it low
    always_comb begin
        logic load_use, md_raw, md_waw, md_struct, dst_ok;
        dst_ok    = i_dst_wr && !((ZERO_REG != 0) && (i_dst_addr == '0));
        load_use  = (rs_e || rt_e) && (e_class == CLS_LOAD);
        md_raw    = md_busy_c && md_wr &&
                    ((rs_ok && (i_rs_addr == md_dst)) || (rt_ok && (i_rt_addr == md_dst)));
        md_waw    = md_busy_c && md_wr && dst_ok && (i_dst_addr == md_dst);
        md_struct = is_md_c && (md_cnt > CD_W'(1));
        stall_c   = i_issue_valid && !i_flush && !reset &&
                    (load_use || md_raw || md_waw || md_struct);
    end

    assign accept_c = i_issue_valid && !stall_c && !i_flush;

    // Bypass selects, youngest stage first; a LOAD in E never forwards from E
    always_comb begin
        o_rs_fwd_sel = 2'd0;
        o_rt_fwd_sel = 2'd0;
        if (!reset) begin
            if (rs_e && (e_class != CLS_LOAD)) o_rs_fwd_sel = 2'd1;
            else if (rs_m)                     o_rs_fwd_sel = 2'd2;
            else if (rs_w)                     o_rs_fwd_sel = 2'd3;
            if (rt_e && (e_class != CLS_LOAD)) o_rt_fwd_sel = 2'd1;
            else if (rt_m)                     o_rt_fwd_sel = 2'd2;
            else if (rt_w)                     o_rt_fwd_sel = 2'd3;
        end
    end

    // Shadow pipeline advance; flush kills the E entry instead of passing it to M
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_valid <= 1'b0; e_addr <= '0; e_class <= 2'd0;
            m_valid <= 1'b0; m_addr <= '0; m_class <= 2'd0;
            w_valid <= 1'b0; w_addr <= '0; w_class <= 2'd0;
        end else begin
            e_valid <= accept_c && i_dst_wr && !is_md_c;
            e_addr  <= i_dst_addr;
            e_class <= i_dst_class;
            m_valid <= e_valid && !i_flush;
            m_addr  <= e_addr;
            m_class <= e_class;
            w_valid <= m_valid;
            w_addr  <= m_addr;
            w_class <= m_class;
        end
    end

    // MUL/DIV countdown; a new issue reloads even when the old one is finishing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
            md_dst <= '0;
            md_wr  <= 1'b0;
        end else if (accept_c && is_md_c) begin
            md_cnt <= CD_W'(MULDIV_LAT);
            md_dst <= i_dst_addr;
            md_wr  <= i_dst_wr;
        end else if (md_busy_c) begin
            md_cnt <= md_cnt - CD_W'(1);
        end
    end

    // Saturating stall-cycle counter, clear has priority
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (i_cnt_clear) begin
            stall_cnt <= '0;
        end else if (i_issue_valid && stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign o_stall       = stall_c;
    assign o_muldiv_busy = md_busy_c;
    assign o_stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_ctrlr.sv
// tb_hazard_scoreboard_ctrlr
//  Directed bench: main instance (defaults, ZERO_REG=1, CNT_W=16) and a second
//  instance (ZERO_REG=0, CNT_W=4) driven by the same stimulus.
module tb_hazard_scoreboard_ctrlr;

    logic       clock = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] rs_addr, rt_addr, dst_addr;
    logic       rs_used, rt_used, dst_wr;
    logic [1:0] dst_class;
    logic       flush, cnt_clear;

    logic        stall_a, busy_a;
    logic [1:0]  rs_sel_a, rt_sel_a;
    logic [15:0] count_a;
    logic        stall_b, busy_b;
    logic [1:0]  rs_sel_b, rt_sel_b;
    logic [3:0]  count_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hazard_scoreboard_ctrlr u_dut (
        .clock(clock), .reset(reset), .i_issue_valid(issue_valid),
        .i_rs_addr(rs_addr), .i_rs_used(rs_used), .i_rt_addr(rt_addr), .i_rt_used(rt_used),
        .i_dst_addr(dst_addr), .i_dst_wr(dst_wr), .i_dst_class(dst_class),
        .i_flush(flush), .i_cnt_clear(cnt_clear),
        .o_stall(stall_a), .o_rs_fwd_sel(rs_sel_a), .o_rt_fwd_sel(rt_sel_a),
        .o_muldiv_busy(busy_a), .o_stall_count(count_a)
    );

    hazard_scoreboard_ctrlr #(.ZERO_REG(0), .CNT_W(4)) u_dut_b (
        .clock(clock), .reset(reset), .i_issue_valid(issue_valid),
        .i_rs_addr(rs_addr), .i_rs_used(rs_used), .i_rt_addr(rt_addr), .i_rt_used(rt_used),
        .i_dst_addr(dst_addr), .i_dst_wr(dst_wr), .i_dst_class(dst_class),
        .i_flush(flush), .i_cnt_clear(cnt_clear),
        .o_stall(stall_b), .o_rs_fwd_sel(rs_sel_b), .o_rt_fwd_sel(rt_sel_b),
        .o_muldiv_busy(busy_b), .o_stall_count(count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic [4:0] dst,
                         input logic wr, input logic [1:0] cls, input logic fl);
        issue_valid = v; rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu;
        dst_addr = dst; dst_wr = wr; dst_class = cls; flush = fl;
    endtask

    // Advance one clock edge; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        cnt_clear = 1'b0;
        reset     = 1'b1;
        // Hazard-looking stimulus while reset is held must produce no stall/bypass
        drive(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 2'd2, 0);
        #12;
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_rs_sel", 32'(rs_sel_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // T1: ALU r3 then consumers see sel 1, 2, 3
        drive(1, 5'd1, 0, 5'd0, 0, 5'd3, 1, 2'd0, 0);
        sample(); chk("t1_issue_stall", 32'(stall_a), 32'd0);
        tick();
        drive(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 2'd0, 0);
        sample(); chk("t1_e_stall", 32'(stall_a), 32'd0);
        chk("t1_e_sel", 32'(rs_sel_a), 32'd1);
        tick();
        drive(1, 5'd3, 1, 5'd4, 1, 5'd6, 1, 2'd0, 0);
        sample(); chk("t1_m_sel", 32'(rs_sel_a), 32'd2);
        chk("t1_rt_e_sel", 32'(rt_sel_a), 32'd1);
        tick();
        drive(1, 5'd3, 1, 5'd0, 0, 5'd8, 1, 2'd0, 0);
        sample(); chk("t1_w_sel", 32'(rs_sel_a), 32'd3);
        tick();

        // T2: load-use stall for one cycle then MEM bypass
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 2'd1, 0);
        sample(); chk("t2_lw_stall", 32'(stall_a), 32'd0);
        tick();
        drive(1, 5'd0, 0, 5'd5, 1, 5'd10, 1, 2'd0, 0);
        sample(); chk("t2_use_stall", 32'(stall_a), 32'd1);
        tick();
        sample(); chk("t2_after_stall", 32'(stall_a), 32'd0);
        chk("t2_rt_sel", 32'(rt_sel_a), 32'd2);
        chk("t2_count", 32'(count_a), 32'd1);
        tick();

        // T3: MUL r7 then dependent ADD stalls 4 cycles
        drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd2, 0);
        sample(); chk("t3_mul_stall", 32'(stall_a), 32'd0);
        tick();
        drive(1, 5'd7, 1, 5'd0, 0, 5'd11, 1, 2'd0, 0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("t3_stall_%0d", i), 32'(stall_a), 32'd1);
            chk($sformatf("t3_busy_%0d", i), 32'(busy_a), 32'd1);
            tick();
        end
        sample(); chk("t3_release_stall", 32'(stall_a), 32'd0);
        chk("t3_release_busy", 32'(busy_a), 32'd0);
        chk("t3_release_sel", 32'(rs_sel_a), 32'd0);
        chk("t3_count", 32'(count_a), 32'd5);
        tick();
        // Structural: second MUL while the first still has >1 cycle left
        drive(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 2'd2, 0);
        tick();
        drive(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 2'd2, 0);
        sample(); chk("t3_struct_stall", 32'(stall_a), 32'd1);
        tick();

        // T4: r0 hardwired on instance A, ordinary register on instance B
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 2'd0, 0);
        tick();
        drive(1, 5'd0, 1, 5'd0, 0, 5'd14, 0, 2'd0, 0);
        sample(); chk("t4_zero_sel_a", 32'(rs_sel_a), 32'd0);
        chk("t4_zero_sel_b", 32'(rs_sel_b), 32'd1);
        chk("t4_zero_stall_a", 32'(stall_a), 32'd0);
        chk("t4_zero_stall_b", 32'(stall_b), 32'd0);
        tick();

        // T5: flush suppresses a load-use stall and empties E
        drive(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 2'd1, 0);
        tick();
        drive(1, 5'd9, 1, 5'd0, 0, 5'd15, 0, 2'd0, 1);
        sample(); chk("t5_flush_stall", 32'(stall_a), 32'd0);
        tick();
        drive(1, 5'd9, 1, 5'd0, 0, 5'd15, 0, 2'd0, 0);
        sample(); chk("t5_after_flush_stall", 32'(stall_a), 32'd0);
        tick();

        // T6: clear, then MUL r7 reading r7 back-to-back: 1 accept + 4 stalls repeating
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 0);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        sample(); chk("t6_clear_a", 32'(count_a), 32'd0);
        chk("t6_clear_b", 32'(count_b), 32'd0);
        drive(1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 2'd2, 0);
        tick();
        for (int i = 0; i < 22; i++) tick();
        // 23 cycles: accepts at 0,5,10,15,20 -> 18 stalled cycles
        chk("t6_count_a", 32'(count_a), 32'd18);
        chk("t6_sat_b", 32'(count_b), 32'd15);
        chk("t6_busy_pre", 32'(busy_a), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy_a), 32'd0);
        chk("t6_rst_count_a", 32'(count_a), 32'd0);
        chk("t6_rst_count_b", 32'(count_b), 32'd0);
        chk("t6_rst_stall", 32'(stall_a), 32'd0);
        chk("t6_rst_sel", 32'(rs_sel_a), 32'd0);
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
